// File: rtl/hipass_pkg.sv
// rtl/hipass_pkg.sv - shared lane-status encodings, FSM state type and code width
package hipass_pkg;

    localparam int CODE_W_DFLT = 4;

    localparam logic [1:0] EN_IDLE = 2'b00;
    localparam logic [1:0] EN_READ = 2'b01;
    localparam logic [1:0] EN_REJ  = 2'b10;
    localparam logic [1:0] EN_PASS = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RECV,
        ST_CHECK,
        ST_PASS,
        ST_REJECT,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/car_debounce.sv
// rtl/car_debounce.sv - two-flop synchronizer and debounce counter for the vehicle sensor
module car_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic car,
    output logic car_present
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          present_q, present_d;

    // Count consecutive cycles the synchronized sensor disagrees with the
    // debounced level; flip the level once the disagreement has lasted DEBOUNCE.
    always_comb begin
        sync1_d   = car;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        present_d = present_q;
        if (sync2_q == present_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE)) begin
            present_d = ~present_q;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchronizer, counter and debounced level registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            present_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            present_q <= present_d;
        end
    end

    assign car_present = present_q;

endmodule

// File: rtl/hipass_gate_ctrl.sv
// rtl/hipass_gate_ctrl.sv - toll-lane front end: presence debounce, card frame receive, gate control
module hipass_gate_ctrl
    import hipass_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 32,
    parameter int HOLD     = 16,
    parameter int CODE_W   = CODE_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              car,
    input  logic              card_rx,
    output logic [1:0]        en,
    output logic [CODE_W-1:0] hipass,
    output logic              gate_open
);

    // One counter serves as timeout, bit and hold counter; only one is live per state.
    localparam int CNT_A   = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
    localparam int CNT_MAX = (CNT_A > CODE_W + 2) ? CNT_A : CODE_W + 2;
    localparam int TW      = $clog2(CNT_MAX + 1);

    logic car_present;

    state_t              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [CODE_W+1:0]   sr_q, sr_d;
    logic [1:0]          en_q, en_d;
    logic [CODE_W-1:0]   hipass_q, hipass_d;
    logic                gate_q, gate_d;

    logic [CODE_W-1:0]   rx_code;
    logic                rx_par;
    logic                rx_stop;
    logic                frame_ok;

    car_debounce #(
        .DEBOUNCE    (DEBOUNCE)
    ) u_car_debounce (
        .clk         (clk),
        .rst         (rst),
        .car         (car),
        .car_present (car_present)
    );

    // Frame is shifted in LSB first from the top, so after CODE_W+2 bits the
    // stop bit sits at the MSB, parity below it and the code in the low bits.
    assign rx_code  = sr_q[CODE_W-1:0];
    assign rx_par   = sr_q[CODE_W];
    assign rx_stop  = sr_q[CODE_W+1];
    assign frame_ok = ~(^{rx_par, rx_code}) & rx_stop & (|rx_code);

    // Next state, counters, shift register and registered outputs.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        sr_d     = sr_q;
        hipass_d = hipass_q;
        en_d     = EN_IDLE;
        gate_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (car_present) begin
                    state_d = ST_READ;
                    tmr_d   = '0;
                end
            end
            ST_READ: begin
                if (!car_present) begin
                    state_d = ST_CLEAR;
                end else if (!card_rx) begin
                    state_d = ST_RECV;
                    tmr_d   = '0;
                end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_REJECT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            ST_RECV: begin
                if (!car_present) begin
                    state_d = ST_CLEAR;
                end else begin
                    sr_d = {card_rx, sr_q[CODE_W+1:1]};
                    if (tmr_q == TW'(CODE_W + 1)) begin
                        state_d = ST_CHECK;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (!car_present) begin
                    state_d = ST_CLEAR;
                end else begin
                    hipass_d = rx_code;
                    tmr_d    = '0;
                    state_d  = frame_ok ? ST_PASS : ST_REJECT;
                end
            end
            ST_PASS: begin
                if (!car_present) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_REJECT: begin
                if (tmr_q != TW'(HOLD - 1)) begin
                    tmr_d = tmr_q + TW'(1);
                end else if (!car_present) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The code is only meaningful while a result is shown.
        if (state_d != ST_PASS && state_d != ST_REJECT) begin
            hipass_d = '0;
        end

        case (state_d)
            ST_READ, ST_RECV, ST_CHECK: en_d = EN_READ;
            ST_PASS: begin
                en_d   = EN_PASS;
                gate_d = 1'b1;
            end
            ST_REJECT: en_d = EN_REJ;
            default:   en_d = EN_IDLE;
        endcase
    end

    // State, counter, shift register and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            sr_q     <= '0;
            en_q     <= EN_IDLE;
            hipass_q <= '0;
            gate_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            sr_q     <= sr_d;
            en_q     <= en_d;
            hipass_q <= hipass_d;
            gate_q   <= gate_d;
        end
    end

    assign en        = en_q;
    assign hipass    = hipass_q;
    assign gate_open = gate_q;

endmodule

// File: tb/tb_hipass_gate_ctrl.sv
// tb/tb_hipass_gate_ctrl.sv - directed self-checking bench for hipass_gate_ctrl
module tb_hipass_gate_ctrl;

    logic       clk;
    logic       rst;
    logic       car;
    logic       card_rx;
    logic [1:0] en;
    logic [3:0] hipass;
    logic       gate_open;

    int passed;
    int total;
    int edge_n;

    hipass_gate_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .car       (car),
        .card_rx   (card_rx),
        .en        (en),
        .hipass    (hipass),
        .gate_open (gate_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) step();
    endtask

    // Reset is released between edges; the next rising edge is edge 0.
    task automatic do_reset();
        rst     = 1'b0;
        car     = 1'b0;
        card_rx = 1'b1;
        step();
        step();
        rst    = 1'b1;
        edge_n = -1;
    endtask

    // Start bit, then bits[3:0] code LSB first, bits[4] parity, bits[5] stop.
    task automatic send_frame(input logic [5:0] bits);
        card_rx = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            card_rx = bits[i];
            step();
        end
        card_rx = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({en, hipass, gate_open} !== 7'b0)
            $display("FAIL reset_outputs got en=%b hipass=%b gate=%b exp 00/0000/0", en, hipass, gate_open);
        else passed++;
    endtask

    task automatic test_pass();
        do_reset();
        car = 1'b1;
        wait_edge(6);
        total++;
        if (en !== 2'b00) $display("FAIL t1_en_edge6 got %b exp 00", en); else passed++;
        wait_edge(7);
        total++;
        if (en !== 2'b01) $display("FAIL t1_en_edge7 got %b exp 01", en); else passed++;
        send_frame({1'b1, 1'b1, 4'b1110});
        total++;
        if (en !== 2'b01) $display("FAIL t1_check_en got %b exp 01", en); else passed++;
        step();
        total++;
        if (en !== 2'b11) $display("FAIL t1_pass_en got %b exp 11", en); else passed++;
        total++;
        if (hipass !== 4'b1110) $display("FAIL t1_pass_code got %b exp 1110", hipass); else passed++;
        total++;
        if (gate_open !== 1'b1) $display("FAIL t1_pass_gate got %b exp 1", gate_open); else passed++;
        car = 1'b0;
        wait_edge(22);
        total++;
        if (en !== 2'b11) $display("FAIL t1_still_pass got %b exp 11", en); else passed++;
        step();
        total++;
        if ({en, hipass, gate_open} !== 7'b0)
            $display("FAIL t1_clear got en=%b hipass=%b gate=%b exp 00/0000/0", en, hipass, gate_open);
        else passed++;
    endtask

    task automatic test_bad_parity();
        logic held;
        do_reset();
        car = 1'b1;
        wait_edge(7);
        send_frame({1'b1, 1'b0, 4'b1110});
        car  = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (en !== 2'b10 || hipass !== 4'b1110 || gate_open !== 1'b0) held = 1'b0;
        end
        total++;
        if (held !== 1'b1) $display("FAIL t2_reject_hold got %b exp 1", held); else passed++;
        step();
        total++;
        if ({en, hipass} !== 6'b0) $display("FAIL t2_clear got en=%b hipass=%b exp 00/0000", en, hipass); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        car = 1'b1;
        wait_edge(38);
        total++;
        if (en !== 2'b01) $display("FAIL t3_before_timeout got %b exp 01", en); else passed++;
        step();
        total++;
        if ({en, hipass, gate_open} !== 7'b1000000)
            $display("FAIL t3_timeout got en=%b hipass=%b gate=%b exp 10/0000/0", en, hipass, gate_open);
        else passed++;
    endtask

    task automatic test_bounce();
        logic quiet;
        int   e;
        do_reset();
        quiet = 1'b1;
        while (edge_n < 40) begin
            e   = edge_n + 1;
            car = (e < 3) ? 1'b1 : ((e < 30) ? (e % 2 == 0) : 1'b0);
            step();
            if (en !== 2'b00 || gate_open !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) $display("FAIL t4_bounce_quiet got %b exp 1", quiet); else passed++;
    endtask

    task automatic test_abort();
        logic no_result;
        int   e;
        do_reset();
        no_result = 1'b1;
        while (edge_n < 20) begin
            e       = edge_n + 1;
            car     = (e < 8);
            card_rx = (e != 12);
            step();
            if (en[1] !== 1'b0) no_result = 1'b0;
            if (edge_n == 7) begin
                total++;
                if (en !== 2'b01) $display("FAIL t5_read got %b exp 01", en); else passed++;
            end
            if (edge_n == 14) begin
                total++;
                if (en !== 2'b01) $display("FAIL t5_recv got %b exp 01", en); else passed++;
            end
            if (edge_n == 15) begin
                total++;
                if ({en, hipass} !== 6'b0) $display("FAIL t5_clear got en=%b hipass=%b exp 00/0000", en, hipass); else passed++;
            end
        end
        total++;
        if (no_result !== 1'b1) $display("FAIL t5_no_result got %b exp 1", no_result); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        car = 1'b1;
        wait_edge(7);
        card_rx = 1'b0;
        step();
        card_rx = 1'b1;
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({en, hipass, gate_open} !== 7'b0)
            $display("FAIL t6_async_reset got en=%b hipass=%b gate=%b exp 00/0000/0", en, hipass, gate_open);
        else passed++;
        card_rx = 1'b1;
        step();
        step();
        rst    = 1'b1;
        edge_n = -1;
        wait_edge(6);
        total++;
        if (en !== 2'b00) $display("FAIL t6_en_edge6 got %b exp 00", en); else passed++;
        wait_edge(7);
        total++;
        if (en !== 2'b01) $display("FAIL t6_en_edge7 got %b exp 01", en); else passed++;
        send_frame({1'b1, 1'b0, 4'b1111});
        step();
        total++;
        if (en !== 2'b11) $display("FAIL t6_pass_en got %b exp 11", en); else passed++;
        total++;
        if (hipass !== 4'b1111) $display("FAIL t6_pass_code got %b exp 1111", hipass); else passed++;
        total++;
        if (gate_open !== 1'b1) $display("FAIL t6_pass_gate got %b exp 1", gate_open); else passed++;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        edge_n  = 0;
        rst     = 1'b0;
        car     = 1'b0;
        card_rx = 1'b1;
        test_reset();
        test_pass();
        test_bad_parity();
        test_timeout();
        test_bounce();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
